// File: rtl/switch_conditioner_pkg.sv
// Shared constants for the switch conditioning stage and the picoMIPS top level.
// Benches import the same values, so widths and timings stay in one place.
package switch_conditioner_pkg;

    localparam int SWITCH_SIZE        = 10;
    localparam int SC_DEBOUNCE_CYCLES = 50000;
    localparam int SC_RESET_STRETCH   = 4;

endpackage

// File: rtl/switch_conditioner_synchroniser.sv
// Two-flop synchroniser for a parameterised-width asynchronous bus.
// Only the second stage is meant to be consumed downstream.
module synchroniser #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1;

    // metastability filter: d -> sync1 -> q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Synchronises and debounces the board switches and derives a stretched,
// registered processor reset from the top switch bit.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int WIDTH           = SWITCH_SIZE,
    parameter int DEBOUNCE_CYCLES = SC_DEBOUNCE_CYCLES,
    parameter int RESET_STRETCH   = SC_RESET_STRETCH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic             sw_changed,
    output logic             cpu_reset
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int RST_W = $clog2(RESET_STRETCH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_STRETCH);

    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] cnt;
    logic [RST_W-1:0] rst_cnt;
    logic             bounce;
    logic             saturated;
    logic             update;

    synchroniser #(
        .WIDTH (WIDTH)
    ) u_synchroniser (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (sync2)
    );

    // A mismatch always wins over the saturated update, so a bounce landing on
    // the final count cycle cancels the pending change.
    assign bounce    = (sync2 != candidate);
    assign saturated = (cnt == CNT_MAX);
    assign update    = !bounce && saturated && (candidate != sw_clean);

    // whole-vector debouncer with a saturating stability counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate  <= '0;
            cnt        <= '0;
            sw_clean   <= '0;
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= update;
            if (bounce) begin
                candidate <= sync2;
                cnt       <= '0;
            end else if (!saturated) begin
                cnt <= cnt + 1'b1;
            end else if (update) begin
                sw_clean <= candidate;
            end
        end
    end

    // processor reset stretcher driven by the debounced top switch bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_cnt   <= RST_LOAD;
            cpu_reset <= 1'b1;
        end else begin
            if (sw_clean[WIDTH-1]) begin
                rst_cnt <= RST_LOAD;
            end else if (rst_cnt != '0) begin
                rst_cnt <= rst_cnt - 1'b1;
            end
            cpu_reset <= (rst_cnt != '0) || sw_clean[WIDTH-1];
        end
    end

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Input-conditioning stage that sits directly upstream of the picoMIPS core, between the board switches and the processor's switch input and reset. It synchronises the raw asynchronous `SW` bus into the `clk` domain, debounces the whole vector, and emits a clean switch word with a one-cycle change strobe. It also derives a stretched, glitch-free processor reset from the top switch bit.

## Interface
Parameters:
- `WIDTH`, default 10: switch bus width. Must equal the `SWITCH_SIZE` width. Bit `WIDTH-1` is the reset switch.
- `DEBOUNCE_CYCLES`, default 50000: number of stable cycles required before a change is accepted (1 ms at 50 MHz). Minimum value is 2.
- `RESET_STRETCH`, default 4: number of cycles `cpu_reset` stays asserted after its cause is removed. Minimum value is 1.

Ports:
- `clk`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high reset, from the board power-on reset.
- `sw_raw`  in  WIDTH: raw, asynchronous and bouncy switch inputs.
- `sw_clean`  out  WIDTH: debounced switch word, fed to the core's `SW` input.
- `sw_changed`  out  1: one-cycle pulse, high in the cycle after `sw_clean` takes a new value.
- `cpu_reset`  out  1: registered, active-high reset for the processor core.

## Operation
- **Synchroniser.** Two flops per bit: `sync1 <= sw_raw`, then `sync2 <= sync1`. Nothing downstream samples `sw_raw` or `sync1` directly.
- **Debouncer.** Operates on the whole vector, using a `candidate` register and a single saturating counter `cnt`.
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES)`.
  - If `sync2 != candidate`: load `candidate <= sync2` and set `cnt <= 0`.
  - Otherwise, if `cnt != DEBOUNCE_CYCLES-1`: increment `cnt`.
  - Otherwise (`cnt == DEBOUNCE_CYCLES-1`, saturated): if `candidate != sw_clean`, load `sw_clean <= candidate`. `cnt` holds; it never wraps.
  - Any bounce (`sync2` differing from `candidate`) restarts the count. A change is accepted only after `DEBOUNCE_CYCLES` consecutive matching samples.
- **Change strobe.** `sw_changed` is registered: it is high for exactly one cycle after each `sw_clean` update and low otherwise. Re-accepting an unchanged value produces no pulse.
- **Reset generator.** A down-counter `rst_cnt` with range 0..`RESET_STRETCH`.
  - If `sw_clean[WIDTH-1]` is 1: load `rst_cnt <= RESET_STRETCH`.
  - Otherwise, if `rst_cnt != 0`: decrement it.
  - `cpu_reset` is a register that takes the value `(rst_cnt != 0) || sw_clean[WIDTH-1]` each cycle.
- **Reset values** (on `reset` high): `sync1`, `sync2`, `candidate`, `sw_clean`, `cnt` and `sw_changed` all 0. `rst_cnt` = `RESET_STRETCH`. `cpu_reset` = 1.
- **Reset mid-operation.** Asserting `reset` during a debounce count discards the pending candidate. After release, an input that was already held high is re-debounced from scratch.

## Timing
Latencies are counted from edge 1, the first rising edge that samples a new, stable `sw_raw`:
- `sync2` holds the new value after edge 2.
- `candidate` loads and `cnt` = 0 after edge 3.
- `sw_clean` updates at edge `DEBOUNCE_CYCLES+3`.
- `sw_changed` is high during the cycle following that edge.
- Reset release: `cpu_reset` stays high for `RESET_STRETCH` cycles after the first edge with `reset` low, provided `sw_clean[WIDTH-1]` is 0.
- Reset switch dropped: when `sw_clean[WIDTH-1]` falls, `cpu_reset` falls `RESET_STRETCH+1` edges later.
- Simultaneous bounce on the saturating cycle: a `sync2` mismatch takes priority over the update, so there is no update and `cnt <= 0`.
- Throughput: one accepted change per `DEBOUNCE_CYCLES+1` cycles at most.

## Structure
- `WIDTH` is derived from the existing `SWITCH_SIZE` macro in the shared constants file. `DEBOUNCE_CYCLES` and `RESET_STRETCH` are added to the same file as named constants, so the top level and benches share them.
- One sub-module, `synchroniser`: a parameterised-width two-flop synchroniser with asynchronous reset. It is instantiated once, for `sw_raw`.
- The debounce counter and the reset stretcher stay inline in `switch_conditioner`.
- The picoMIPS top level instantiates this block and drives the core from `sw_clean` and `cpu_reset` in place of the raw `SW` bus.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES=4`, `RESET_STRETCH=4`, and a 20 ns clock.

1. **Reset values.** Assert `reset`, release it with `sw_raw=0` → `sw_clean=0`, `sw_changed=0`, `cpu_reset=1` for 4 cycles after release, then 0.
2. **Clean change.** Step `sw_raw` from `0x000` to `0x055` and hold → `sw_clean=0x055` at edge 7 (`DEBOUNCE_CYCLES+3`), `sw_changed` high for exactly one cycle, `cpu_reset` stays 0.
3. **Bounce.** Toggle `sw_raw` bit 0 on alternate cycles for 10 cycles, then hold at 1 → `sw_clean` does not change until edge 7 counted from the last transition; exactly one `sw_changed` pulse.
4. **Reset switch.** Set `sw_raw[9]=1` and hold for 20 cycles, then 0 → `cpu_reset` rises one edge after `sw_clean[9]`, and falls 5 edges after `sw_clean[9]` falls.
5. **Reset mid-count.** Step `sw_raw` to `0x0F0`, then assert `reset` for one cycle at `cnt=2` → `sw_clean` stays 0; after release, the update arrives 7 edges after the first post-reset edge.
6. **Short glitch.** Drive a one-cycle pulse on `sw_raw=0x001` → `sw_clean` unchanged and no `sw_changed` pulse.
